// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Purpose  : Shared types and width defaults for the data-RAM arbiter slice.
//            Provides the requester port id, the read-return pipeline entry
//            and the default data/address widths used by ram_arbiter.
// Contents : c_BIT_DATA, c_SZB_RAM   default data / RAM address widths
//            port_e                   requester id (PORT_CPU / PORT_IO)
//            rtn_t                    {valid, port} read-tracking entry
// Revision : 1.0  initial release
// ============================================================================
package ram_arbiter_pkg;

   localparam int c_BIT_DATA = 8;
   localparam int c_SZB_RAM  = 8;

   // Requester identity; also the encoding of the last-grant state.
   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_IO  = 1'b1
   } port_e;

   // One in-flight read: whether the slot is occupied and who asked for it.
   typedef struct packed {
      logic  valid;
      port_e port;
   } rtn_t;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_rtn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_rtn_pipe
// Purpose  : Two-stage {valid, port} shift pipeline that follows each
//            accepted read from acceptance to the cycle its RAM data is on
//            ram_q. Stage 1 mirrors the registered RAM command, stage 2
//            lines up with the synchronous RAM output.
// Ports    : clock       in   rising-edge clock
//            reset       in   synchronous active-low clear of both stages
//            push_valid  in   a read is accepted on this edge
//            push_port   in   port that issued the accepted read
//            rtn_valid   out  stage-2 valid: read data is on ram_q now
//            rtn_port    out  stage-2 port id
//            pending     out  any stage holds a read
// Revision : 1.0  initial release
// ============================================================================
module ram_rtn_pipe
   import ram_arbiter_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  logic  push_valid,
   input  port_e push_port,
   output logic  rtn_valid,
   output port_e rtn_port,
   output logic  pending
);

   localparam rtn_t c_RTN_EMPTY = '{valid: 1'b0, port: PORT_CPU};

   rtn_t r_stage1;
   rtn_t r_stage2;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_stage1 <= c_RTN_EMPTY;
         r_stage2 <= c_RTN_EMPTY;
      end else begin
         r_stage1 <= '{valid: push_valid, port: push_port};
         r_stage2 <= r_stage1;
      end
   end

   assign rtn_valid = r_stage2.valid;
   assign rtn_port  = r_stage2.port;
   assign pending   = r_stage1.valid | r_stage2.valid;

endmodule : ram_rtn_pipe
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares a single-port synchronous data RAM between the CPU
//            load/store path and the IO loader. One access is granted per
//            cycle, round-robin on ties, IO-first while interrupt is high.
//            The winning command is registered toward the RAM and read data
//            is steered back to the issuing port two cycles after acceptance.
// Ports    : clock, reset            clock / sync active-low reset
//            interrupt               IO gets absolute priority while high
//            cpu_req/we/addr/wdata   CPU request (held until granted)
//            cpu_gnt                 combinational grant
//            cpu_rvalid/rdata        CPU read return (1-cycle pulse)
//            io_*                    same set for the IO port
//            ram_we/addr_ram/ram_d   registered RAM command
//            ram_q                   RAM read data (1 cycle after address)
//            busy                    a read is still in flight
// Revision : 1.0  initial release
// ============================================================================
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int BIT_DATA = c_BIT_DATA,
   parameter int SZB_RAM  = c_SZB_RAM
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                interrupt,

   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [SZB_RAM-1:0]  cpu_addr,
   input  logic [BIT_DATA-1:0] cpu_wdata,
   output logic                cpu_gnt,
   output logic                cpu_rvalid,
   output logic [BIT_DATA-1:0] cpu_rdata,

   input  logic                io_req,
   input  logic                io_we,
   input  logic [SZB_RAM-1:0]  io_addr,
   input  logic [BIT_DATA-1:0] io_wdata,
   output logic                io_gnt,
   output logic                io_rvalid,
   output logic [BIT_DATA-1:0] io_rdata,

   output logic                ram_we,
   output logic [SZB_RAM-1:0]  addr_ram,
   output logic [BIT_DATA-1:0] ram_d,
   input  logic [BIT_DATA-1:0] ram_q,

   output logic                busy
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   port_e               r_last_gnt;
   logic                r_ram_we;
   logic [SZB_RAM-1:0]  r_addr_ram;
   logic [BIT_DATA-1:0] r_ram_d;
   logic [BIT_DATA-1:0] r_cpu_rdata_hold;
   logic [BIT_DATA-1:0] r_io_rdata_hold;

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic                w_cpu_gnt;
   logic                w_io_gnt;
   logic                w_accept;
   port_e               w_win_port;
   logic                w_win_we;
   logic [SZB_RAM-1:0]  w_win_addr;
   logic [BIT_DATA-1:0] w_win_wdata;
   logic                w_rtn_valid;
   port_e               w_rtn_port;
   logic                w_pending;
   logic                w_cpu_rvalid;
   logic                w_io_rvalid;

   // ------------------------------------------------------------------
   // Grant selection. Grants are forced low while reset is asserted so
   // nothing can appear accepted during the reset cycle.
   // ------------------------------------------------------------------
   always_comb begin
      w_cpu_gnt = 1'b0;
      w_io_gnt  = 1'b0;
      if (reset) begin
         if (cpu_req && io_req) begin
            // Tie: IO under interrupt, otherwise whoever did not win last.
            if (interrupt || (r_last_gnt == PORT_CPU)) begin
               w_io_gnt = 1'b1;
            end else begin
               w_cpu_gnt = 1'b1;
            end
         end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
         end else if (io_req) begin
            w_io_gnt = 1'b1;
         end
      end
   end

   assign cpu_gnt  = w_cpu_gnt;
   assign io_gnt   = w_io_gnt;
   assign w_accept = w_cpu_gnt | w_io_gnt;

   // Winner's command; only meaningful when w_accept is high.
   always_comb begin
      w_win_port  = PORT_CPU;
      w_win_we    = cpu_we;
      w_win_addr  = cpu_addr;
      w_win_wdata = cpu_wdata;
      if (w_io_gnt) begin
         w_win_port  = PORT_IO;
         w_win_we    = io_we;
         w_win_addr  = io_addr;
         w_win_wdata = io_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Command register and round-robin state. Address and write data only
   // load on acceptance so they hold across idle cycles; the write enable
   // is a single-cycle strobe per accepted write.
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ram_we   <= 1'b0;
         r_addr_ram <= '0;
         r_ram_d    <= '0;
         r_last_gnt <= PORT_IO;   // so the first tie after reset goes to CPU
      end else begin
         r_ram_we <= w_accept & w_win_we;
         if (w_accept) begin
            r_addr_ram <= w_win_addr;
            r_ram_d    <= w_win_wdata;
            r_last_gnt <= w_win_port;
         end
      end
   end

   assign ram_we   = r_ram_we;
   assign addr_ram = r_addr_ram;
   assign ram_d    = r_ram_d;

   // ------------------------------------------------------------------
   // Read return tracking
   // ------------------------------------------------------------------
   ram_rtn_pipe u_rtn_pipe (
      .clock      (clock),
      .reset      (reset),
      .push_valid (w_accept & ~w_win_we),
      .push_port  (w_win_port),
      .rtn_valid  (w_rtn_valid),
      .rtn_port   (w_rtn_port),
      .pending    (w_pending)
   );

   assign w_cpu_rvalid = w_rtn_valid && (w_rtn_port == PORT_CPU);
   assign w_io_rvalid  = w_rtn_valid && (w_rtn_port == PORT_IO);

   // Read data is passed straight from ram_q in the return cycle; the hold
   // registers keep each port's last returned word stable afterwards.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cpu_rdata_hold <= '0;
         r_io_rdata_hold  <= '0;
      end else begin
         if (w_cpu_rvalid) begin
            r_cpu_rdata_hold <= ram_q;
         end
         if (w_io_rvalid) begin
            r_io_rdata_hold <= ram_q;
         end
      end
   end

   assign cpu_rvalid = w_cpu_rvalid;
   assign io_rvalid  = w_io_rvalid;
   assign cpu_rdata  = w_cpu_rvalid ? ram_q : r_cpu_rdata_hold;
   assign io_rdata   = w_io_rvalid  ? ram_q : r_io_rdata_hold;
   assign busy       = w_pending;

endmodule : ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port data RAM between two requesters: the CPU core (load/store path) and the IO loader (external `io_din` writes and `io_dout` readback). It sits between the controller/datapath and the RAM pins (`ram_we`, `addr_ram`, `ram_d`, `ram_q`). It grants one access per cycle with round-robin fairness, or IO-first while `interrupt` is high. It registers the winning command toward the RAM and routes read data back to the requester that issued it, with a fixed latency.

## Interface
- `BIT_DATA`, default `` `BIT_DATA ``: data width.
- `SZB_RAM`, default `` `SZB_RAM ``: RAM address width.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; reset applies when `reset==0` at a rising edge.
- `interrupt`  in  1  while high, the IO port has absolute priority.
- `cpu_req`  in  1  CPU access request, held until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  SZB_RAM  access address.
- `cpu_wdata`  in  BIT_DATA  write data.
- `cpu_gnt`  out  1  combinational; the request is accepted on the edge where `cpu_req && cpu_gnt`.
- `cpu_rvalid`  out  1  read data valid, one-cycle pulse.
- `cpu_rdata`  out  BIT_DATA  read data.
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_gnt`, `io_rvalid`, `io_rdata`: same as the `cpu_*` group, for the IO port.
- `ram_we`  out  1  registered RAM write enable.
- `addr_ram`  out  SZB_RAM  registered RAM address.
- `ram_d`  out  BIT_DATA  registered RAM write data.
- `ram_q`  in  BIT_DATA  RAM read data. The RAM is synchronous: `ram_q` is valid one cycle after `addr_ram` is presented.
- `busy`  out  1  high while any accepted read is still in flight.

## Operation
**Grant selection** is combinational on the current requests and the state `last_gnt` (0 = CPU, 1 = IO):
- One requester active: that requester wins.
- Both active and `interrupt==1`: IO wins.
- Both active and `interrupt==0`: the port other than `last_gnt` wins.
- Exactly one `*_gnt` is high per cycle. Both grants are 0 when there is no request or while `reset==0`.

**On an accepted request at edge N:**
- `ram_we`, `addr_ram` and `ram_d` load the winner's `we`, `addr` and `wdata`; these are valid in cycle N+1.
- `last_gnt` updates to the winner, including under `interrupt`.
- In any cycle with no acceptance, `ram_we` returns to 0. `addr_ram` and `ram_d` hold their last values.

**Read return:**
- A 2-stage pipeline of `{valid, port}` tracks each read.
- The issuing port sees `*_rvalid=1` and `*_rdata=ram_q` in cycle N+2.
- The other port's `rvalid` stays 0; its `rdata` holds its last value.
- Writes generate no `rvalid`.

**Other rules:**
- Back-to-back acceptance every cycle is allowed; throughput is 1 access per cycle.
- A read at address A accepted the cycle after a write to A returns the new data, since the RAM write lands before the read is issued.
- `busy` = OR of the pipeline valid bits.

## Timing
- **Reset** (`reset==0` at an edge):
  - `ram_we`, `addr_ram`, `ram_d` reset to 0.
  - Pipeline valid bits clear, so both `*_rvalid` and `busy` are 0.
  - Both `*_rdata` reset to 0.
  - `last_gnt` resets to 1, so the CPU wins the first tie.
- **Reset mid-operation:** in-flight reads are dropped and never return `rvalid`. A command accepted in the reset cycle is discarded.
- **Latency:**
  - Grant is same-cycle.
  - RAM command is presented 1 cycle after acceptance.
  - Read data returns 2 cycles after acceptance.
- **Ties:** strict alternation under continuous dual requests: C, I, C, I, and so on.
- **Interrupt:** the IO port can starve the CPU indefinitely while `interrupt` is high. After `interrupt` falls, the next tie goes to whichever port did not win last.
- **Request changes:** a requester dropping `req` before it is granted is legal; nothing is issued.

## Structure
- Add `` `PORT_CPU `` (1'b0) and `` `PORT_IO `` (1'b1) to the shared `definitions.v`. Widths come from the existing `` `BIT_DATA `` and `` `SZB_RAM ``.
- One sub-module, `ram_rtn_pipe`: the 2-stage `{valid, port}` shift pipeline with synchronous active-low clear. It outputs the valid flag and port id for the stage-2 return.
- Grant logic, the command register and `last_gnt` live in `ram_arbiter`.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles with both requests high → all outputs 0 and no grant. Release reset with both requesting → `cpu_gnt=1` in the first cycle.
- **CPU write then read:** CPU writes 0x5A to address 3 at edge N → `ram_we=1`, `addr_ram=3`, `ram_d=0x5A` in cycle N+1. CPU reads address 3 at edge N+1 → `cpu_rvalid=1`, `cpu_rdata=0x5A` in cycle N+3, and `io_rvalid` stays 0.
- **Alternation:** both ports issue reads continuously for 6 cycles, `interrupt=0` → grants go C, I, C, I, C, I, and each rvalid arrives on its own port 2 cycles after its grant.
- **Interrupt priority:** both requesting with `interrupt=1` for 4 cycles → `io_gnt` on all 4 cycles. Drop `interrupt` → the next tie goes to the CPU.
- **Reset mid-flight:** IO read accepted at edge N, `reset=0` at edge N+1 → no `io_rvalid` in cycle N+2, `busy=0`.
- **Idle:** no requests → `ram_we=0`, `addr_ram` holds its last value, `busy=0`.
